// File: rtl/piso_serializer_16_bit.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clock,
// framing strobes on the first and last bit of each word.
module piso_serializer_16_bit #(
    parameter int   DATA_WIDTH = 16,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_Start_Out,
    output logic                  Frame_End_Out,
    output logic                  Busy_Out
);

    // state    | meaning
    // ST_IDLE  | no word in flight, line parked at IDLE_LEVEL
    // ST_SHIFT | presenting bit cnt_q of the captured word

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   shreg_q;

    logic                    busy;
    logic                    last_bit;
    logic                    accept;
    logic                    tx_bit;
    logic [DATA_WIDTH-1:0]   shreg_next;

    assign busy     = (state_q == ST_SHIFT);
    assign last_bit = busy && (cnt_q == LAST_CNT);
    assign accept   = Load_Valid_In && Load_Ready_Out;

    assign shreg_next = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg_q[DATA_WIDTH-1:1]};
    assign tx_bit     = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (Enable_In) begin
            if (accept) begin
                state_q <= ST_SHIFT;
                cnt_q   <= '0;
                shreg_q <= Parallel_Data_In;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            shreg_q <= shreg_next;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs come straight from the state registers; Enable_In only gates them.
    assign Load_Ready_Out   = Enable_In && (!busy || last_bit);
    assign Busy_Out         = busy;
    assign Serial_Valid_Out = Enable_In && busy;
    assign Frame_Start_Out  = Enable_In && busy && (cnt_q == '0);
    assign Frame_End_Out    = Enable_In && last_bit;
    assign Serial_Data_Out  = Enable_In ? (busy ? tx_bit : IDLE_LEVEL) : 1'bz;

endmodule
